ptw: RTL
========

PTW -- requirements
Module: ptw

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles one memory access may wait for mem_ack_i.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ptw_req_i  input  1  walk request pulse from TLB.
REQ-005 ptw_vaddr_i  input  32  virtual address to translate; valid with ptw_req_i.
REQ-006 satp_ppn_i  input  20  root page-table PPN; sampled with ptw_req_i.
REQ-007 ptw_resp_valid_o  output  1  one-cycle response strobe.
REQ-008 ptw_pte_o  output  32  leaf PTE; valid with ptw_resp_valid_o.
REQ-009 ptw_fault_o  output  1  walk failed; valid with ptw_resp_valid_o.
REQ-010 mem_req_o  output  1  memory read request, held until acknowledged.
REQ-011 mem_addr_o  output  32  PTE byte address; stable while mem_req_o=1.
REQ-012 mem_ack_i  input  1  read complete; mem_rdata_i valid this cycle.
REQ-013 mem_rdata_i  input  32  PTE read data.
REQ-014 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-015 PTE format SHALL be: [31:12] PPN; [0] R; [1] W; [2] V; [31:3] other bits ignored except PPN.
REQ-016 The FSM SHALL have states IDLE, L1_WAIT, L0_WAIT, RESP.
REQ-017 In IDLE, ptw_req_i=1 SHALL capture vaddr and satp_ppn, drive mem_addr_o={satp_ppn, vaddr[31:22], 2'b00}, set mem_req_o=1, and go to L1_WAIT.
REQ-018 ptw_req_i outside IDLE SHALL be ignored, with no queuing.
REQ-019 mem_req_o and mem_addr_o SHALL stay constant until the edge sampling mem_ack_i=1; mem_ack_i SHALL be ignored while mem_req_o=0.
REQ-020 L1_WAIT on ack: V=0 → fault; R|W≠0 (superpage) → fault; otherwise (pointer) drive mem_addr_o={rdata[31:12], vaddr[21:12], 2'b00}, keep mem_req_o=1, and go to L0_WAIT back-to-back.
REQ-021 L0_WAIT on ack: V=0 or R=W=0 → fault; otherwise success with the PTE captured unmodified.
REQ-022 Success or fault SHALL drop mem_req_o on the next edge and enter RESP. In RESP, ptw_resp_valid_o=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-023 On fault, ptw_pte_o SHALL be 0 and ptw_fault_o=1. On success, ptw_pte_o=leaf PTE and ptw_fault_o=0.
REQ-024 ptw_fault_o and ptw_pte_o SHALL be 0 whenever ptw_resp_valid_o=0.
REQ-025 An 8-bit wait counter SHALL clear on each new memory request and increment each cycle mem_req_o=1 without ack. When the count equals TIMEOUT_CYCLES, the access SHALL end as a fault: mem_req_o drops and a late ack is ignored.
REQ-026 A simultaneous ack and timeout SHALL take the ack.
REQ-027 Minimum latency is 4 cycles from ptw_req_i to ptw_resp_valid_o, with single-cycle acks on a two-level success.
REQ-028 An L1 fault SHALL issue no L0 access.
REQ-029 ptw_req_i in the RESP cycle SHALL be ignored; a new request is accepted only from the first cycle back in IDLE.

Reset
REQ-030 rst=1 SHALL force IDLE; clear all outputs and internal registers to 0; abort any walk, including mid-access, with no response.
REQ-031 After reset release, mem_ack_i from an aborted access SHALL be ignored because mem_req_o=0.

Verification
REQ-032 Success: satp_ppn=0x00010, vaddr=0x12345678 → mem_addr 0x00010120; ack rdata=0x00020004 → mem_addr 0x00020D14; ack rdata=0x0ABCD007 → resp_valid pulse, pte=0x0ABCD007, fault=0.
REQ-033 L1 invalid: same vaddr, L1 rdata=0x00020000 → resp fault=1, pte=0, only one mem_req issued.
REQ-034 Superpage/L0 non-leaf: L1 rdata=0x00020005 → fault. Separately, L0 rdata=0x00030004 → fault.
REQ-035 Timeout: hold mem_ack_i=0 → mem_req_o drops after 255 cycles; fault response; a later ack is ignored.
REQ-036 Handshake: 5-cycle ack delay keeps mem_addr stable throughout; ptw_req_i pulses while busy are ignored (one response only).
REQ-037 Reset mid-walk: rst during L0_WAIT → all outputs 0, IDLE; next request walks normally from L1.

Source files
------------

// File: rtl/ptw_if.sv
// PTW bus bundle: TLB walk request/response plus the PTE memory read port.
// slave is the walker side; master is the TLB/memory environment.
interface ptw_if;
    logic        ptw_req_i;
    logic [31:0] ptw_vaddr_i;
    logic [19:0] satp_ppn_i;
    logic        ptw_resp_valid_o;
    logic [31:0] ptw_pte_o;
    logic        ptw_fault_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    modport slave (
        input  ptw_req_i, ptw_vaddr_i, satp_ppn_i, mem_ack_i, mem_rdata_i,
        output ptw_resp_valid_o, ptw_pte_o, ptw_fault_o, mem_req_o, mem_addr_o, busy_o
    );

    modport master (
        output ptw_req_i, ptw_vaddr_i, satp_ppn_i, mem_ack_i, mem_rdata_i,
        input  ptw_resp_valid_o, ptw_pte_o, ptw_fault_o, mem_req_o, mem_addr_o, busy_o
    );
endinterface

// File: rtl/ptw.sv
// Two-level (Sv32-style) page-table walker with per-access ack timeout.
// One walk at a time; requests arriving while busy are dropped.
module ptw #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic  clk,
    input logic  rst,
    ptw_if.slave bus
);
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StL1Wait = 2'd1;
    localparam logic [1:0] StL0Wait = 2'd2;
    localparam logic [1:0] StResp   = 2'd3;

    localparam logic [8:0] TimeoutLim = TIMEOUT_CYCLES[8:0];

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [9:0]  vpn0_q, vpn0_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] pte_q, pte_d;
    logic        fault_q, fault_d;

    logic pte_v, pte_r, pte_w, timeout;
    logic unused_vaddr_lsb;

    assign pte_v = bus.mem_rdata_i[2];
    assign pte_r = bus.mem_rdata_i[0];
    assign pte_w = bus.mem_rdata_i[1];

    // Fires on the edge where the wait count would reach the limit.
    assign timeout = ({1'b0, wait_cnt_q} + 9'd1) == TimeoutLim;

    assign unused_vaddr_lsb = ^bus.ptw_vaddr_i[11:0];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        vpn0_d     = vpn0_q;
        wait_cnt_d = wait_cnt_q;
        pte_d      = pte_q;
        fault_d    = fault_q;
        case (state_q)
            StIdle: begin
                if (bus.ptw_req_i) begin
                    addr_d     = {bus.satp_ppn_i, bus.ptw_vaddr_i[31:22], 2'b00};
                    vpn0_d     = bus.ptw_vaddr_i[21:12];
                    wait_cnt_d = 8'd0;
                    state_d    = StL1Wait;
                end
            end
            StL1Wait: begin
                if (bus.mem_ack_i) begin
                    if (!pte_v || pte_r || pte_w) begin
                        pte_d   = 32'd0;
                        fault_d = 1'b1;
                        state_d = StResp;
                    end else begin
                        addr_d     = {bus.mem_rdata_i[31:12], vpn0_q, 2'b00};
                        wait_cnt_d = 8'd0;
                        state_d    = StL0Wait;
                    end
                end else if (timeout) begin
                    pte_d   = 32'd0;
                    fault_d = 1'b1;
                    state_d = StResp;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StL0Wait: begin
                if (bus.mem_ack_i) begin
                    if (!pte_v || (!pte_r && !pte_w)) begin
                        pte_d   = 32'd0;
                        fault_d = 1'b1;
                    end else begin
                        pte_d   = bus.mem_rdata_i;
                        fault_d = 1'b0;
                    end
                    state_d = StResp;
                end else if (timeout) begin
                    pte_d   = 32'd0;
                    fault_d = 1'b1;
                    state_d = StResp;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StResp: begin
                pte_d   = 32'd0;
                fault_d = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= 32'd0;
            vpn0_q     <= 10'd0;
            wait_cnt_q <= 8'd0;
            pte_q      <= 32'd0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            vpn0_q     <= vpn0_d;
            wait_cnt_q <= wait_cnt_d;
            pte_q      <= pte_d;
            fault_q    <= fault_d;
        end
    end

    // Response regs are only non-zero while in StResp.
    assign bus.ptw_resp_valid_o = (state_q == StResp);
    assign bus.ptw_pte_o        = pte_q;
    assign bus.ptw_fault_o      = fault_q;
    assign bus.mem_req_o        = (state_q == StL1Wait) || (state_q == StL0Wait);
    assign bus.mem_addr_o       = addr_q;
    assign bus.busy_o           = (state_q != StIdle);
endmodule
